kse_entry_ctrl: RTL and testbench

Entry controller sitting between the KSE keypad scanner/encoder and the system consumer. It sequences the scanner's `valid`/`read` handshake, assembles accepted key codes into a multi-digit entry, and handles clear (`*`) and enter (`#`) keys plus an inter-key timeout. It presents the completed entry to the consumer through a ready/ack handshake and backpressures the scanner while an entry is pending.

---
 rtl/kse_pkg.sv | 46 ++++
 rtl/kse_timeout_ctr.sv | 41 ++++
 rtl/kse_entry_ctrl.sv | 159 +++++++++++++++
 tb/tb_kse_entry_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kse_pkg.sv
// Shared definitions for the KSE keypad path: key codes, entry-controller
// state encoding and the nibble layout of the scanner's 8-bit BCD bus.
package kse_pkg;

  localparam int unsigned KSE_BCD_W = 8;
  localparam int unsigned KEY_W     = 4;

  localparam logic [KEY_W-1:0] KEY_STAR      = 4'hE;
  localparam logic [KEY_W-1:0] KEY_HASH      = 4'hF;
  localparam logic [KEY_W-1:0] KEY_DIGIT_MAX = 4'h9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONSUME = 2'd1,
    S_DRAIN   = 2'd2,
    S_READY   = 2'd3
  } kse_state_e;

  // Only the low nibble of the scanner bus carries the key; the high nibble is don't-care.
  typedef struct packed {
    logic [KSE_BCD_W-KEY_W-1:0] rsvd;
    logic [KEY_W-1:0]           key;
  } kse_bcd_t;

  typedef enum logic [1:0] {
    KEY_CLS_DIGIT  = 2'd0,
    KEY_CLS_LETTER = 2'd1,
    KEY_CLS_STAR   = 2'd2,
    KEY_CLS_HASH   = 2'd3
  } kse_key_cls_e;

  function automatic kse_key_cls_e kse_classify(input logic [KEY_W-1:0] key);
    kse_key_cls_e cls;
    if (key <= KEY_DIGIT_MAX) begin
      cls = KEY_CLS_DIGIT;
    end else if (key == KEY_STAR) begin
      cls = KEY_CLS_STAR;
    end else if (key == KEY_HASH) begin
      cls = KEY_CLS_HASH;
    end else begin
      cls = KEY_CLS_LETTER;
    end
    return cls;
  endfunction

endpackage

// File: rtl/kse_timeout_ctr.sv
// Inter-key idle counter: cleared by key activity, counts while enabled and
// flags expiry on the edge where it reaches TIMEOUT_CYCLES-1.
module kse_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_c_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             expire_c;

  // A clear on the same edge always beats expiry.
  assign expire_c   = enable_i && !clear_i && (cnt_q == CNT_LAST);
  assign expire_c_o = expire_c;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = expire_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/kse_entry_ctrl.sv
// Keypad entry controller: sequences the KSE valid/read handshake, builds a
// multi-digit entry and hands it to the consumer over a ready/ack handshake.
module kse_entry_ctrl
  import kse_pkg::*;
#(
  parameter int unsigned MAX_DIGITS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               kse_valid,
  input  logic [7:0]                         kse_bcd,
  output logic                               kse_read,
  output logic [4*MAX_DIGITS-1:0]            code,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    code_len,
  output logic                               code_ready,
  input  logic                               code_ack,
  output logic                               timeout,
  output logic                               overflow
);

  localparam int unsigned CODE_W = 4 * MAX_DIGITS;
  localparam int unsigned LEN_W  = $clog2(MAX_DIGITS + 1);

  kse_state_e        state_q;
  logic [CODE_W-1:0] code_q;
  logic [LEN_W-1:0]  len_q;
  logic              read_q;
  logic              ready_q;
  logic              timeout_q;
  logic              overflow_q;
  logic              hash_go_q;

  kse_bcd_t          bcd_c;
  kse_key_cls_e      cls_c;
  logic              key_accept_c;
  logic              ack_c;
  logic              len_full_c;
  logic              ctr_clear_c;
  logic              ctr_enable_c;
  logic              expire_c;
  logic [CODE_W-1:0] code_shift_c;
  logic              unused_bcd_hi;

  assign bcd_c         = kse_bcd_t'(kse_bcd);
  assign unused_bcd_hi = ^bcd_c.rsvd;
  assign cls_c         = kse_classify(bcd_c.key);

  assign key_accept_c  = (state_q == S_IDLE) && kse_valid;
  assign ack_c         = (state_q == S_READY) && code_ack;
  assign len_full_c    = (len_q == LEN_W'(MAX_DIGITS));
  assign code_shift_c  = (code_q << 4) | CODE_W'(bcd_c.key);

  // Idle timer only runs on a partial entry that the consumer has not yet seen.
  assign ctr_clear_c   = key_accept_c || ack_c;
  assign ctr_enable_c  = (len_q != '0) && (state_q != S_READY);

  kse_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (ctr_clear_c),
    .enable_i   (ctr_enable_c),
    .expire_c_o (expire_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      len_q      <= '0;
      read_q     <= 1'b0;
      ready_q    <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      hash_go_q  <= 1'b0;
    end else begin
      read_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (kse_valid) begin
            state_q   <= S_CONSUME;
            read_q    <= 1'b1;
            hash_go_q <= 1'b0;
            case (cls_c)
              KEY_CLS_DIGIT: begin
                if (len_full_c) begin
                  overflow_q <= 1'b1;
                end else begin
                  code_q <= code_shift_c;
                  len_q  <= len_q + LEN_W'(1);
                end
              end
              KEY_CLS_STAR: begin
                code_q <= '0;
                len_q  <= '0;
              end
              KEY_CLS_HASH: begin
                hash_go_q <= (len_q != '0);
              end
              default: begin
              end
            endcase
          end
        end

        S_CONSUME: begin
          state_q <= S_DRAIN;
        end

        // Hold here until the scanner drops valid so one assertion yields one key.
        S_DRAIN: begin
          if (!kse_valid) begin
            hash_go_q <= 1'b0;
            if (hash_go_q && !expire_c) begin
              state_q <= S_READY;
              ready_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        S_READY: begin
          if (code_ack) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            code_q  <= '0;
            len_q   <= '0;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Expiry never coincides with an accepted key, so it can override the case above.
      if (expire_c) begin
        code_q    <= '0;
        len_q     <= '0;
        timeout_q <= 1'b1;
        hash_go_q <= 1'b0;
      end
    end
  end

  assign kse_read   = read_q;
  assign code       = code_q;
  assign code_len   = len_q;
  assign code_ready = ready_q;
  assign timeout    = timeout_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_kse_entry_ctrl.sv
// Directed bench for kse_entry_ctrl: entries checked through a scoreboard of
// expected completed codes, handshakes and pulses checked with immediate assertions.
module tb_kse_entry_ctrl;

  localparam int unsigned MAX_DIGITS     = 4;
  localparam int unsigned TIMEOUT_CYCLES = 20;

  typedef struct packed {
    logic [15:0] code;
    logic [2:0]  len;
  } exp_entry_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        kse_valid = 1'b0;
  logic [7:0]  kse_bcd = 8'h00;
  logic        kse_read;
  logic [15:0] code;
  logic [2:0]  code_len;
  logic        code_ready;
  logic        code_ack = 1'b0;
  logic        timeout;
  logic        overflow;

  int n_assert = 0;
  int n_fail   = 0;
  int read_cnt = 0;
  int to_cnt   = 0;
  int ovf_cnt  = 0;

  exp_entry_t sb[$];

  kse_entry_ctrl #(
    .MAX_DIGITS     (MAX_DIGITS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .kse_valid  (kse_valid),
    .kse_bcd    (kse_bcd),
    .kse_read   (kse_read),
    .code       (code),
    .code_len   (code_len),
    .code_ready (code_ready),
    .code_ack   (code_ack),
    .timeout    (timeout),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  // Cycle counts of each single-cycle output.
  always @(posedge clock) begin
    if (kse_read === 1'b1) read_cnt <= read_cnt + 1;
    if (timeout === 1'b1)  to_cnt   <= to_cnt + 1;
    if (overflow === 1'b1) ovf_cnt  <= ovf_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required < 100000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One key: valid for a single sample, then low through CONSUME and DRAIN.
  task automatic press(input logic [7:0] bcd);
    kse_valid = 1'b1;
    kse_bcd   = bcd;
    tick();
    kse_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_entry(input string tag, input logic [15:0] c, input logic [2:0] l);
    check({tag, "_code"}, 32'(code), 32'(c));
    check({tag, "_len"}, 32'(code_len), 32'(l));
  endtask

  task automatic wait_ready_and_pop(input int budget);
    exp_entry_t e;
    int k = 0;
    while (code_ready !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check("ready_within_budget", 32'(code_ready), 32'd1);
    e = sb.pop_front();
    check_entry("sb_entry", e.code, e.len);
  endtask

  initial begin
    int rc0;
    int to0;
    int to_edge;

    // Reset state
    tick();
    tick();
    check("rst_kse_read", 32'(kse_read), 32'd0);
    check_entry("rst", 16'h0000, 3'd0);
    check("rst_code_ready", 32'(code_ready), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick();

    // Basic entry 1,2,3,#
    rc0 = read_cnt;
    press(8'h01);
    press(8'h02);
    press(8'h03);
    check_entry("basic_digits", 16'h0123, 3'd3);
    sb.push_back('{code: 16'h0123, len: 3'd3});
    kse_valid = 1'b1;
    kse_bcd   = 8'h0F;
    tick();
    check("hash_read_pulse", 32'(kse_read), 32'd1);
    kse_valid = 1'b0;
    tick();
    check("ready_not_early", 32'(code_ready), 32'd0);
    tick();
    wait_ready_and_pop(4);
    check("basic_reads", 32'(read_cnt - rc0), 32'd4);
    code_ack = 1'b1;
    tick();
    code_ack = 1'b0;
    check("ack_ready_low", 32'(code_ready), 32'd0);
    check_entry("ack_cleared", 16'h0000, 3'd0);

    // Clear and overflow
    press(8'h05);
    press(8'h0E);
    press(8'h07);
    check_entry("star_clear", 16'h0007, 3'd1);
    press(8'h01);
    press(8'h02);
    press(8'h03);
    check("no_ovf_yet", 32'(ovf_cnt), 32'd0);
    kse_valid = 1'b1;
    kse_bcd   = 8'h04;
    tick();
    check("ovf_pulse", 32'(overflow), 32'd1);
    kse_valid = 1'b0;
    tick();
    tick();
    check("ovf_once", 32'(ovf_cnt), 32'd1);
    check_entry("ovf_entry", 16'h7123, 3'd4);
    press(8'h0E);
    check_entry("clear_full", 16'h0000, 3'd0);

    // Backpressure while READY
    press(8'h08);
    sb.push_back('{code: 16'h0008, len: 3'd1});
    press(8'h0F);
    kse_valid = 1'b1;
    kse_bcd   = 8'h02;
    rc0 = read_cnt;
    for (int i = 0; i < 5; i++) tick();
    check("bp_no_read", 32'(read_cnt - rc0), 32'd0);
    check("bp_still_ready", 32'(code_ready), 32'd1);
    wait_ready_and_pop(4);
    code_ack = 1'b1;
    tick();
    code_ack = 1'b0;
    check("bp_ack_ready_low", 32'(code_ready), 32'd0);
    check_entry("bp_ack_cleared", 16'h0000, 3'd0);
    tick();
    check("bp_key_read", 32'(kse_read), 32'd1);
    kse_valid = 1'b0;
    tick();
    tick();
    check_entry("bp_key_applied", 16'h0002, 3'd1);

    // Timeout: key 9 then idle
    to0 = to_cnt;
    to_edge = -1;
    press(8'h09);
    check_entry("to_before", 16'h0029, 3'd2);
    for (int k = 3; k <= 25; k++) begin
      tick();
      if (k == 18) check("to_len_held", 32'(code_len), 32'd2);
      if (timeout === 1'b1 && to_edge < 0) to_edge = k;
    end
    check("to_latency", 32'(to_edge), 32'd19);
    check("to_single_pulse", 32'(to_cnt - to0), 32'd1);
    check_entry("to_cleared", 16'h0000, 3'd0);

    // Key landing exactly on the expiry edge
    to0 = to_cnt;
    press(8'h09);
    for (int k = 3; k <= 18; k++) tick();
    kse_valid = 1'b1;
    kse_bcd   = 8'h06;
    tick();
    check("race_no_timeout", 32'(timeout), 32'd0);
    check_entry("race_appended", 16'h0096, 3'd2);
    kse_valid = 1'b0;
    tick();
    tick();
    check("race_no_pulse", 32'(to_cnt - to0), 32'd0);
    press(8'h0E);

    // Held key with high nibble set
    rc0 = read_cnt;
    kse_valid = 1'b1;
    kse_bcd   = 8'h53;
    for (int i = 0; i < 10; i++) tick();
    kse_valid = 1'b0;
    tick();
    tick();
    check("held_one_read", 32'(read_cnt - rc0), 32'd1);
    check_entry("held_one_digit", 16'h0003, 3'd1);

    // Hash on empty entry is ignored
    press(8'h0E);
    rc0 = read_cnt;
    press(8'hAF);
    tick();
    check("hash_empty_read", 32'(read_cnt - rc0), 32'd1);
    check("hash_empty_not_ready", 32'(code_ready), 32'd0);
    check_entry("hash_empty_entry", 16'h0000, 3'd0);

    // Letter keys consumed without effect
    press(8'hC4);
    rc0 = read_cnt;
    for (int b = 10; b <= 13; b++) press(8'(b));
    check("letters_read", 32'(read_cnt - rc0), 32'd4);
    check_entry("letters_entry", 16'h0004, 3'd1);
    check("letters_not_ready", 32'(code_ready), 32'd0);

    // Reset while draining a held key
    press(8'h0E);
    press(8'h01);
    press(8'h02);
    kse_valid = 1'b1;
    kse_bcd   = 8'h0A;
    tick();
    tick();
    check_entry("pre_reset", 16'h0012, 3'd2);
    reset = 1'b1;
    rc0 = read_cnt;
    tick();
    check("mid_rst_read", 32'(kse_read), 32'd0);
    check_entry("mid_rst", 16'h0000, 3'd0);
    check("mid_rst_ready", 32'(code_ready), 32'd0);
    kse_valid = 1'b0;
    reset = 1'b0;
    tick();
    check("mid_rst_no_read", 32'(read_cnt - rc0), 32'd0);
    press(8'h06);
    check_entry("post_rst_idle", 16'h0006, 3'd1);
    check("post_rst_read", 32'(read_cnt - rc0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
